// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int SCAN_DIV_DEF = 4;
    localparam int DEBOUNCE_DEF = 8;

    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] ROW_FIRST = 4'b1110;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kstate_t;

    // True when exactly one active-low line is asserted.
    function automatic logic single_low(input logic [3:0] v);
        return $onehot(~v);
    endfunction

    // Active-low row rotation: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] next_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer bringing the raw keypad columns into the clk domain.
module col_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Idle (no key) is all ones, so both stages reset to that value.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= COL_IDLE;
            q    <= COL_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad front end with press/release debounce.
// Emits a single key_valid pulse per accepted press and latches the
// active-low row/column pattern for the downstream key decoder.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SCAN     | rotate rows, sample columns in last cycle of each row slot
//   DEBOUNCE | row frozen, count consecutive cycles matching captured col
//   HELD     | key accepted, wait for columns to go idle
//   RELEASE  | count consecutive idle cycles before resuming the scan
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_FULL = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    kstate_t       state;
    logic [3:0]    scol;
    logic [3:0]    row_q;
    logic [3:0]    cap_col;
    logic [CW-1:0] div_cnt;
    logic [CW-1:0] deb_cnt;
    logic          scol_match;
    logic          scol_idle;

    col_sync u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col),
        .q     (scol)
    );

    // Row register doubles as the captured row while a key is being tracked.
    assign row        = row_q;
    assign scol_match = (scol == cap_col);
    assign scol_idle  = (scol == COL_IDLE);

    // Scan/debounce controller: row rotation, key capture and output latching.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SCAN;
            row_q     <= ROW_FIRST;
            cap_col   <= COL_IDLE;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            key_row   <= ROW_IDLE;
            key_col   <= COL_IDLE;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                ST_SCAN: begin
                    // Earlier cycles of a row slot are settling time for the
                    // column lines and the synchronizer; only the last counts.
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (single_low(scol)) begin
                            cap_col <= scol;
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            row_q <= next_row(row_q);
                        end
                    end else begin
                        div_cnt <= div_cnt + CNT_ONE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!scol_match) begin
                        deb_cnt <= '0;
                        row_q   <= next_row(row_q);
                        state   <= ST_SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt   <= DEB_FULL;
                        key_row   <= row_q;
                        key_col   <= cap_col;
                        key_valid <= 1'b1;
                        state     <= ST_HELD;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end

                ST_HELD: begin
                    // Other columns on the same row keep scol non-idle, so a
                    // second key only extends the hold; it never re-triggers.
                    if (scol_idle) begin
                        deb_cnt <= '0;
                        state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!scol_idle) begin
                        deb_cnt <= '0;
                        state   <= ST_HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        row_q   <= next_row(row_q);
                        state   <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad closes the loop
// from row to col, expected keys are queued as presses are made and popped
// whenever the scanner pulses key_valid.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_valid;

    logic       kp_on;
    logic [3:0] kp_row;
    logic [3:0] kp_col;

    logic [7:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         pulses   = 0;
    int         base;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_valid (key_valid)
    );

    // Physical keypad: the pressed key pulls its column low only while its row is driven.
    assign col = (kp_on && (row == kp_row)) ? kp_col : 4'b1111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected scan row k cycles after leaving reset with no key accepted.
    function automatic logic [3:0] rot(input int k);
        logic [3:0] seq [4];
        seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        return seq[(k / 4) % 4];
    endfunction

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (pulses < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 8'(pulses >= target), 8'd1);
    endtask

    // Scoreboard side: every pulse must match the oldest queued key; row always one-cold.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (!reset) begin
            check("row_one_cold", 8'($onehot(~row)), 8'd1);
            if (key_valid === 1'b1) begin
                pulses++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'bx;
                check("pulse_vs_scoreboard", {key_row, key_col}, exp);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        kp_on  = 1'b0;
        kp_row = 4'b1111;
        kp_col = 4'b1111;
        repeat (3) @(negedge clk);

        check("reset_row",       {4'h0, row},     {4'h0, 4'b1110});
        check("reset_key_row",   {4'h0, key_row}, {4'h0, 4'b1111});
        check("reset_key_col",   {4'h0, key_col}, {4'h0, 4'b1111});
        check("reset_key_valid", {7'h0, key_valid}, 8'h00);
        reset = 1'b0;

        // Idle scanning: four-cycle row slots in fixed rotation.
        for (int k = 0; k < 64; k++) begin
            check("idle_row", {4'h0, row}, {4'h0, rot(k)});
            step();
        end
        check("idle_no_pulse", 8'(pulses), 8'd0);

        // Clean press on row 1011, column 1101.
        base   = pulses;
        kp_row = 4'b1011;
        kp_col = 4'b1101;
        kp_on  = 1'b1;
        exp_q.push_back({4'b1011, 4'b1101});
        repeat (40) step();
        check("clean_pulse_count", 8'(pulses - base), 8'd1);
        check("clean_key_row", {4'h0, key_row}, {4'h0, 4'b1011});
        check("clean_key_col", {4'h0, key_col}, {4'h0, 4'b1101});
        kp_on = 1'b0;
        repeat (20) step();

        // Bouncing press on row 1110, column 1110, then stable.
        base   = pulses;
        kp_row = 4'b1110;
        kp_col = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            kp_on = (((i / 3) % 2) == 1);
            step();
        end
        check("bounce_no_pulse", 8'(pulses - base), 8'd0);
        kp_on = 1'b1;
        exp_q.push_back({4'b1110, 4'b1110});
        repeat (9) step();
        check("bounce_no_early_pulse", 8'(pulses - base), 8'd0);
        wait_pulses(base + 1, 60, "bounce_pulse_timeout");
        repeat (20) step();
        check("bounce_pulse_count", 8'(pulses - base), 8'd1);
        kp_on = 1'b0;
        repeat (20) step();

        // Long hold, bouncy release, clean release, re-press.
        base   = pulses;
        kp_row = 4'b0111;
        kp_col = 4'b1011;
        kp_on  = 1'b1;
        exp_q.push_back({4'b0111, 4'b1011});
        repeat (200) step();
        check("hold_single_pulse", 8'(pulses - base), 8'd1);
        check("hold_key_row", {4'h0, key_row}, {4'h0, 4'b0111});
        for (int i = 0; i < 12; i++) begin
            kp_on = (((i / 2) % 2) == 1);
            step();
        end
        kp_on = 1'b0;
        repeat (20) step();
        check("release_bounce_no_pulse", 8'(pulses - base), 8'd1);
        check("release_keeps_key_col", {4'h0, key_col}, {4'h0, 4'b1011});
        exp_q.push_back({4'b0111, 4'b1011});
        kp_on = 1'b1;
        wait_pulses(base + 2, 40, "repress_pulse_timeout");
        repeat (5) step();
        check("repress_two_pulses", 8'(pulses - base), 8'd2);
        kp_on = 1'b0;
        repeat (20) step();

        // Two columns low on one row: never accepted, scan keeps rotating.
        reset  = 1'b1;
        kp_row = 4'b1101;
        kp_col = 4'b1100;
        kp_on  = 1'b1;
        step();
        step();
        reset = 1'b0;
        base  = pulses;
        for (int k = 0; k < 50; k++) begin
            check("ghost_row", {4'h0, row}, {4'h0, rot(k)});
            step();
        end
        check("ghost_no_pulse", 8'(pulses - base), 8'd0);
        check("ghost_key_row", {4'h0, key_row}, {4'h0, 4'b1111});
        check("ghost_key_col", {4'h0, key_col}, {4'h0, 4'b1111});

        // Reset mid-debounce: capture at cycle 4 after reset, count reaches 5 after cycle 9.
        kp_on = 1'b0;
        reset = 1'b1;
        step();
        kp_row = 4'b1110;
        kp_col = 4'b1110;
        kp_on  = 1'b1;
        step();
        reset = 1'b0;
        base  = pulses;
        repeat (9) step();
        reset = 1'b1;
        step();
        check("midreset_row",       {4'h0, row},     {4'h0, 4'b1110});
        check("midreset_key_valid", {7'h0, key_valid}, 8'h00);
        check("midreset_key_row",   {4'h0, key_row}, {4'h0, 4'b1111});
        check("midreset_key_col",   {4'h0, key_col}, {4'h0, 4'b1111});
        reset = 1'b0;
        exp_q.push_back({4'b1110, 4'b1110});
        repeat (10) step();
        check("midreset_no_early_pulse", 8'(pulses - base), 8'd0);
        wait_pulses(base + 1, 30, "midreset_pulse_timeout");
        check("midreset_key_row_after", {4'h0, key_row}, {4'h0, 4'b1110});
        check("midreset_key_col_after", {4'h0, key_col}, {4'h0, 4'b1110});
        kp_on = 1'b0;
        repeat (20) step();

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
